riscv_muldiv_seq: RTL and testbench

//  Iterative sequencer for the RV32M extension (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).

---
 rtl/riscv_muldiv_seq_pkg.sv | 40 ++++
 rtl/riscv_muldiv_seq_if.sv | 29 ++
 rtl/riscv_muldiv_seq.sv | 135 +++++++++++++
 tb/tb_riscv_muldiv_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_seq_pkg.sv
// riscv_muldiv_seq_pkg: RV32M decode constants, sequencer state encoding and operand-sign helpers.
// Revision 1.0
`default_nettype none

package riscv_muldiv_seq_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'd1;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic [2:0] funct3;
    logic       negate;
  } op_ctl_t;

  function automatic logic rs1_is_signed(input logic [2:0] f);
    return (f != MULDIV_MULHU) && (f != MULDIV_DIVU) && (f != MULDIV_REMU);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f);
    return (f == MULDIV_MUL) || (f == MULDIV_MULH) || (f == MULDIV_DIV) || (f == MULDIV_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_muldiv_seq_if.sv
// riscv_muldiv_seq_if: request/response bundle between the execute stage and the mul/div sequencer.
// Revision 1.0
`default_nettype none

interface riscv_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            kill;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, kill,
    input  in_ready, busy, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, kill,
    output in_ready, busy, out_valid, out_result
  );
endinterface

`default_nettype wire

// File: rtl/riscv_muldiv_seq.sv
// riscv_muldiv_seq: iterative RV32M unit, one shift-add / restoring-divide bit per cycle.
// Revision 1.0
`default_nettype none

module riscv_muldiv_seq
  import riscv_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic           clock,
  input  wire logic           reset,
  riscv_muldiv_seq_if.slave   bus
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   counter;
  op_ctl_t         ctl;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] result;

  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  // Two's-complement negation of 1<<(XLEN-1) yields itself, which is exactly
  // its unsigned magnitude, so XLEN-bit magnitudes lose nothing.
  always_comb begin
    sign1 = rs1_is_signed(bus.in_funct3) & bus.in_rs1[XLEN-1];
    sign2 = rs2_is_signed(bus.in_funct3) & bus.in_rs2[XLEN-1];
    mag1  = sign1 ? (~bus.in_rs1 + 1'b1) : bus.in_rs1;
    mag2  = sign2 ? (~bus.in_rs2 + 1'b1) : bus.in_rs2;

    div_zero = bus.in_funct3[2] && (bus.in_rs2 == '0);
    div_ovf  = bus.in_funct3[2] && !bus.in_funct3[0] &&
               (bus.in_rs1 == MIN_NEG) && (bus.in_rs2 == '1);
    if (div_zero)
      special_res = bus.in_funct3[1] ? bus.in_rs1 : '1;
    else
      special_res = bus.in_funct3[1] ? '0 : bus.in_rs1;
  end

  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  always_comb begin
    prod_fix = ctl.negate ? -{acc, lo} : {acc, lo};
    quot_fix = ctl.negate ? -lo : lo;
    rem_fix  = ctl.negate ? -acc : acc;
    if (ctl.funct3[2])
      fix_res = ctl.funct3[1] ? rem_fix : quot_fix;
    else if (ctl.funct3 == MULDIV_MUL)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      ctl     <= '0;
      acc     <= '0;
      lo      <= '0;
      opb     <= '0;
      result  <= '0;
    end else if (bus.kill) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            ctl.funct3 <= bus.in_funct3;
            // Remainder follows the dividend sign; everything else takes the product/quotient sign.
            ctl.negate <= (bus.in_funct3[2] && bus.in_funct3[1]) ? sign1 : (sign1 ^ sign2);
            counter    <= '0;
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= ST_DONE;
            end else begin
              acc   <= '0;
              lo    <= mag1;
              opb   <= mag2;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (ctl.funct3[2]) begin
            if (!div_diff[XLEN]) begin
              acc <= div_diff[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], 1'b1};
            end else begin
              acc <= div_shift[XLEN-1:0];
              lo  <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
          counter <= counter + CW'(1);
          if (counter == LAST_BIT)
            state <= ST_FIX;
        end
        ST_FIX: begin
          result <= fix_res;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.out_result = result;

endmodule

`default_nettype wire

// File: tb/tb_riscv_muldiv_seq.sv
// tb_riscv_muldiv_seq: directed RV32M vectors with hand-computed results, latency and kill/reset behaviour.
// Revision 1.0
`default_nettype none

module tb_riscv_muldiv_seq;
  import riscv_muldiv_seq_pkg::*;

  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  riscv_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  riscv_muldiv_seq #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; on return the bench sits in cycle T+1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'($urandom);
    bus.in_rs1    = $urandom;
    bus.in_rs2    = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    int busy_bad = 0;
    issue(f3, a, b);
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clock);
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, bus.out_result, exp);
    check({tag, " busy"}, busy_bad, 0);
    @(negedge clock);
    check({tag, " pulse end"}, 32'(bus.out_valid), 32'd0);
    check({tag, " ready after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.kill      = 1'b0;
    bus.in_funct3 = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    repeat (2) @(negedge clock);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_result", bus.out_result, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul",      MULDIV_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh",     MULDIV_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 34);
    run_op("mulhu",    MULDIV_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu",   MULDIV_MULHSU, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 34);
    run_op("mulh neg", MULDIV_MULH,   32'h80000000,  32'hFFFFFFFF, 32'h00000000, 34);
    run_op("div",      MULDIV_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",      MULDIV_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34);
    run_op("div pn",   MULDIV_DIV,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFFE, 34);
    run_op("rem pn",   MULDIV_REM,    32'd7,         32'hFFFFFFFD, 32'h00000001, 34);
    run_op("div min",  MULDIV_DIV,    32'h80000000,  32'd2,        32'hC0000000, 34);
    run_op("divu",     MULDIV_DIVU,   32'd100,       32'd7,        32'd14,       34);
    run_op("remu",     MULDIV_REMU,   32'd100,       32'd7,        32'd2,        34);
    run_op("divu0",    MULDIV_DIVU,   32'd5,         32'd0,        32'hFFFFFFFF, 1);
    run_op("remu0",    MULDIV_REMU,   32'd5,         32'd0,        32'd5,        1);
    run_op("rem0",     MULDIV_REM,    32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 1);
    run_op("div ovf",  MULDIV_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem ovf",  MULDIV_REM,    32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1);

    // Abort a divide in cycle T+10, then issue a new op in the very next cycle.
    issue(MULDIV_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    check("kill in_ready", 32'(bus.in_ready), 32'd1);
    check("kill out_valid", 32'(bus.out_valid), 32'd0);
    check("kill out_result", bus.out_result, 32'h00000000);
    run_op("b2b remu", MULDIV_REMU, 32'd100, 32'd7, 32'd2, 34);

    bus.kill      = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_funct3 = MULDIV_DIVU;
    bus.in_rs1    = 32'd5;
    bus.in_rs2    = 32'd0;
    @(negedge clock);
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    check("kill idle busy", 32'(bus.busy), 32'd0);
    check("kill idle out_valid", 32'(bus.out_valid), 32'd0);
    check("kill idle out_result", bus.out_result, 32'd2);

    issue(MULDIV_DIVU, 32'd9, 32'd0);
    bus.kill = 1'b1;
    #1;
    check("kill done out_valid", 32'(bus.out_valid), 32'd1);
    check("kill done out_result", bus.out_result, 32'hFFFFFFFF);
    @(negedge clock);
    bus.kill = 1'b0;
    check("kill done ready", 32'(bus.in_ready), 32'd1);

    issue(MULDIV_MUL, 32'd3, 32'd5);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset out_result", bus.out_result, 32'h0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b0) pulses++;
    end
    check("midreset no pulse", pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
